// File: rtl/adder_nbit_seq.sv
// Multi-cycle ripple adder: adds CHUNK bits per clock with a valid/ready handshake on both sides.
// Optional subtract mode (sub port, a + ~b + 1) is built only when ADDER_SUB_EN is defined.
module adder_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("adder_nbit_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_res;
  logic              last_chunk;
  int                shamt;

  // Subtraction is folded into the operands at accept time so BUSY only ever adds.
`ifdef ADDER_SUB_EN
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : carry_in;
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = carry_in;
  end
`endif

  always_comb begin
    shamt      = int'(idx_q) * CHUNK;
    a_chunk    = a_q[shamt +: CHUNK];
    b_chunk    = b_q[shamt +: CHUNK];
    chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == IDXW'(NCHUNK - 1));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d         = a;
          b_d         = b_eff;
          carry_d     = cin_eff;
          idx_d       = '0;
          sum_d       = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (k == int'(idx_q)) begin
            sum_d[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
          end
        end
        carry_d = chunk_res[CHUNK];
        if (last_chunk) begin
          // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
          carry_out_d = chunk_res[CHUNK];
          overflow_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
          idx_d       = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Directed self-checking bench for adder_nbit_seq (WIDTH=16, CHUNK=4).
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_adder_nbit_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int tests_run;
  int tests_failed;

  adder_nbit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input logic sb);
    a        = av;
    b        = bv;
    carry_in = ci;
    sub      = sb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 0000 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic ci,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_co,
                          input logic exp_ov);
    int lat;
    start_op(av, bv, ci, 1'b0);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_busy_ready: got %b want 0", name, in_ready);
    end
    wait_done(lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got %0d want 4", name, lat);
    end
    tests_run++;
    if (sum !== exp_sum || carry_out !== exp_co || overflow !== exp_ov) begin
      tests_failed++;
      $display("[TB] FAIL %s_result: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
               name, sum, carry_out, overflow, exp_sum, exp_co, exp_ov);
    end
    release_result();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_return_idle: got rdy=%b vld=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    // New operands offered while BUSY must be ignored.
    a        = 16'hAAAA;
    b        = 16'h0001;
    in_valid = 1'b1;
    wait_done(lat);
    tests_run++;
    if (out_valid !== 1'b1 || sum !== 16'h3333) begin
      tests_failed++;
      $display("[TB] FAIL bp_first_result: got vld=%b sum=%h want 1 3333", out_valid, sum);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333 ||
          carry_out !== 1'b0 || overflow !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%h co=%b ov=%b want 1 0 3333 0 0",
                 i, out_valid, in_ready, sum, carry_out, overflow);
      end
    end
    in_valid = 1'b0;
    release_result();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int pulses;
    start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_async: got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_result: got pulses=%0d rdy=%b want 0 1", pulses, in_ready);
    end
    start_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat !== 4 || sum !== 16'h0007 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_next_op: got lat=%0d sum=%h co=%b ov=%b want 4 0007 0 0",
               lat, sum, carry_out, overflow);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h0101;
    b         = 16'h0202;
    carry_in  = 1'b1;
    tick();
    out_ready = 1'b0;
    // The handshake edge must not also accept the waiting operands.
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_no_same_cycle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    tests_run++;
    if (lat !== 4 || sum !== 16'h0304 || carry_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got lat=%0d sum=%h co=%b want 4 0304 0", lat, sum, carry_out);
    end
    release_result();
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(lat);
    tests_run++;
    if (sum !== 16'hFFFE || carry_out !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sub_borrow: got sum=%h co=%b ov=%b want FFFE 0 0", sum, carry_out, overflow);
    end
    release_result();
    start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_done(lat);
    tests_run++;
    if (sum !== 16'h7FFF || carry_out !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sub_overflow: got sum=%h co=%b ov=%b want 7FFF 1 1", sum, carry_out, overflow);
    end
    release_result();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    a            = '0;
    b            = '0;
    carry_in     = 1'b0;
    sub          = 1'b0;

    test_reset();
    test_add("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    test_add("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("pos_ovf",  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    test_add("neg_ovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_add("ripple",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    test_add("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef ADDER_SUB_EN
    test_sub();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
